// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: shared datapath widths and condition-flag encoding for the execute-stage FUs
package Purple_Jade_pkg;

    localparam int WORD_SIZE_P = 16;
    localparam int NUM_FLAGS   = 4;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
        logic v;
    } flags_t;

endpackage

// File: rtl/flag_comb.sv
// flag_comb: combinational C/N/Z/V derivation for a result word
module flag_comb
    import Purple_Jade_pkg::*;
#(
    parameter int WORD_SIZE_P = Purple_Jade_pkg::WORD_SIZE_P
) (
    input  logic [WORD_SIZE_P-1:0] result,
    input  logic                   carry,
    input  logic                   overflow,
    output flags_t                 flags
);

    // N and Z come from the result word only, so an X there cannot leak into C or V
    always_comb begin
        flags.c = carry;
        flags.n = result[WORD_SIZE_P-1];
        flags.z = ~|result;
        flags.v = overflow;
    end

endmodule

// File: rtl/flag_gen.sv
// flag_gen: same-cycle condition flags plus a masked, registered architectural copy
module flag_gen
    import Purple_Jade_pkg::*;
#(
    parameter int WORD_SIZE_P = Purple_Jade_pkg::WORD_SIZE_P
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [WORD_SIZE_P-1:0] result_i,
    input  logic                   carry_i,
    input  logic                   overflow_i,
    input  logic [NUM_FLAGS-1:0]   mask_i,
    output logic [NUM_FLAGS-1:0]   flags_o,
    output logic [NUM_FLAGS-1:0]   flags_r_o,
    output logic                   flags_v_o
);

    flags_t flags;
    flags_t flags_r;
    logic   flags_v;

    flag_comb #(.WORD_SIZE_P(WORD_SIZE_P)) u_comb (
        .result   (result_i),
        .carry    (carry_i),
        .overflow (overflow_i),
        .flags    (flags)
    );

    // Valid results merge new flags into the architectural copy under the per-flag mask
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flags_r <= '0;
            flags_v <= 1'b0;
        end else begin
            flags_v <= v_i;
            if (v_i)
                flags_r <= (flags & mask_i) | (flags_r & ~mask_i);
        end
    end

    assign flags_o   = flags;
    assign flags_r_o = flags_r;
    assign flags_v_o = flags_v;

endmodule

// File: tb/tb_flag_gen.sv
// tb_flag_gen: directed vector table plus reset corner sequences for flag_gen
module tb_flag_gen;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [15:0] result_i;
    logic        carry_i;
    logic        overflow_i;
    logic [3:0]  mask_i;
    logic [3:0]  flags_o;
    logic [3:0]  flags_r_o;
    logic        flags_v_o;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [15:0] res;
        logic        c;
        logic        o;
        logic [3:0]  mask;
        logic [3:0]  exp_f;
        logic [3:0]  exp_r;
        logic        exp_v;
    } vec_t;

    vec_t vecs[8];

    flag_gen dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .result_i   (result_i),
        .carry_i    (carry_i),
        .overflow_i (overflow_i),
        .mask_i     (mask_i),
        .flags_o    (flags_o),
        .flags_r_o  (flags_r_o),
        .flags_v_o  (flags_v_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic c, input logic o,
                         input logic [3:0] mask);
        v_i = v;
        result_i = res;
        carry_i = c;
        overflow_i = o;
        mask_i = mask;
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1};
        vecs[1] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1100, 4'b1100, 4'b1110, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'b1111, 4'b0010, 4'b1110, 1'b0};
        vecs[3] = '{1'b1, 16'h8001, 1'b1, 1'b1, 4'b0000, 4'b1101, 4'b1110, 1'b1};
        vecs[4] = '{1'b1, 16'h7FFF, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1};
        vecs[5] = '{1'b1, 16'h8001, 1'b1, 1'b1, 4'b0001, 4'b1101, 4'b0001, 1'b1};
        vecs[6] = '{1'b1, 16'h0000, 1'b0, 1'b1, 4'b1010, 4'b0011, 4'b0011, 1'b1};
        vecs[7] = '{1'b1, 16'h8000, 1'b1, 1'b0, 4'b1111, 4'b1100, 4'b1100, 1'b1};

        reset_i = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
        #1;
        check4("reset_flags_r", flags_r_o, 4'b0000);
        check4("reset_flags_v", {3'b0, flags_v_o}, 4'b0000);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            drive(vecs[i].v, vecs[i].res, vecs[i].c, vecs[i].o, vecs[i].mask);
            #1;
            check4($sformatf("vec%0d_flags", i), flags_o, vecs[i].exp_f);
            @(posedge clk_i);
            #1;
            check4($sformatf("vec%0d_flags_r", i), flags_r_o, vecs[i].exp_r);
            check4($sformatf("vec%0d_flags_v", i), {3'b0, flags_v_o}, {3'b0, vecs[i].exp_v});
        end

        @(negedge clk_i);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111);
        @(negedge clk_i);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 4'b0010);
        @(posedge clk_i);
        #1;
        check4("pre_reset_flags_r", flags_r_o, 4'b1110);

        @(negedge clk_i);
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 4'b1111);
        #1;
        reset_i = 1'b1;
        #1;
        check4("async_reset_flags_r", flags_r_o, 4'b0000);
        check4("async_reset_flags_v", {3'b0, flags_v_o}, 4'b0000);
        @(posedge clk_i);
        #1;
        check4("reset_wins_flags_r", flags_r_o, 4'b0000);
        check4("reset_wins_flags_v", {3'b0, flags_v_o}, 4'b0000);

        drive(1'b1, 16'h0000, 1'b0, 1'b0, 4'b1111);
        #1;
        check4("reset_comb_0000", flags_o, 4'b0010);
        result_i = 16'h0001;
        #1;
        check4("reset_comb_0001", flags_o, 4'b0000);
        result_i = 16'h8000;
        #1;
        check4("reset_comb_8000", flags_o, 4'b0100);

        @(negedge clk_i);
        reset_i = 1'b0;
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 4'b1111);
        @(posedge clk_i);
        #1;
        check4("first_update_flags_r", flags_r_o, 4'b0010);
        check4("first_update_flags_v", {3'b0, flags_v_o}, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
